// File: rtl/FLP_pkg.sv
// Floating-point datapath constants and the butterfly result record
// shared between the add stage and its write-back buffer.
package FLP_pkg;

   localparam int unsigned OVERALL_BITS  = 32;
   localparam int unsigned FFT_ADDR_BITS = 10;

   // One butterfly result: both complex outputs and their destinations.
   typedef struct packed {
      logic [OVERALL_BITS-1:0]  a_p_b_real;
      logic [OVERALL_BITS-1:0]  a_p_b_imag;
      logic [OVERALL_BITS-1:0]  a_m_b_real;
      logic [OVERALL_BITS-1:0]  a_m_b_imag;
      logic [FFT_ADDR_BITS-1:0] addr_p;
      logic [FFT_ADDR_BITS-1:0] addr_m;
   } bfly_pair_t;

endpackage

// File: rtl/fft_butterfly_writeback_buffer_pkg.sv
// Local types for the butterfly write-back buffer.
package fft_butterfly_writeback_buffer_pkg;

   // Output serialiser phase: SUM emits a+b, DIFF emits a-b.
   typedef enum logic {
      PH_SUM  = 1'b0,
      PH_DIFF = 1'b1
   } phase_e;

endpackage

// File: rtl/fft_pair_fifo.sv
// Synchronous FIFO of butterfly result pairs with full/empty/count.
// A write while full is dropped even if a read happens in the same cycle.
module fft_pair_fifo
   import FLP_pkg::*;
#(
   parameter  int unsigned DEPTH    = 8,
   localparam int unsigned CNT_BITS = $clog2(DEPTH + 1),
   localparam int unsigned PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  bfly_pair_t          wr_data,
   input  logic                rd_en,
   output bfly_pair_t          rd_data,
   output logic                full,
   output logic                empty,
   output logic [CNT_BITS-1:0] count
);

   bfly_pair_t          mem [DEPTH];
   logic [PTR_BITS-1:0] wr_ptr;
   logic [PTR_BITS-1:0] rd_ptr;
   logic                wr_acc;
   logic                rd_acc;

   assign full    = (count == CNT_BITS'(DEPTH));
   assign empty   = (count == '0);
   assign wr_acc  = wr_en & ~full;
   assign rd_acc  = rd_en & ~empty;
   assign rd_data = mem[rd_ptr];

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_BITS'(1);
         if (rd_acc) rd_ptr <= rd_ptr + PTR_BITS'(1);
         count <= count + CNT_BITS'(wr_acc) - CNT_BITS'(rd_acc);
      end
   end

   // Storage array; contents need no reset.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/fft_butterfly_writeback_buffer.sv
// Captures butterfly result pairs from the add stage, buffers them, and
// serialises each pair as two complex words (a+b then a-b) to memory.
// Upstream flow control is credit based: a butterfly may only start when
// a FIFO slot is guaranteed to be free at its done.
module fft_butterfly_writeback_buffer
   import FLP_pkg::*;
   import fft_butterfly_writeback_buffer_pkg::*;
#(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned ADDR_BITS = FFT_ADDR_BITS
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    issue,
   output logic                    issue_ok,
   input  logic                    in_done,
   input  logic [OVERALL_BITS-1:0] in_a_p_b_real,
   input  logic [OVERALL_BITS-1:0] in_a_p_b_imag,
   input  logic [OVERALL_BITS-1:0] in_a_m_b_real,
   input  logic [OVERALL_BITS-1:0] in_a_m_b_imag,
   input  logic [ADDR_BITS-1:0]    in_addr_p,
   input  logic [ADDR_BITS-1:0]    in_addr_m,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OVERALL_BITS-1:0] out_real,
   output logic [OVERALL_BITS-1:0] out_imag,
   output logic [ADDR_BITS-1:0]    out_addr,
   output logic                    empty,
   output logic                    overflow_err
);

   localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

   bfly_pair_t          wr_pair;
   bfly_pair_t          head;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CNT_BITS-1:0] occ;
   logic [CNT_BITS-1:0] inflight;
   logic [CNT_BITS:0]   committed;
   logic                issue_acc;
   logic                done_credit;
   logic                xfer;
   logic                pop;
   phase_e              phase;
   phase_e              phase_next;

   assign wr_pair.a_p_b_real = in_a_p_b_real;
   assign wr_pair.a_p_b_imag = in_a_p_b_imag;
   assign wr_pair.a_m_b_real = in_a_m_b_real;
   assign wr_pair.a_m_b_imag = in_a_m_b_imag;
   assign wr_pair.addr_p     = in_addr_p;
   assign wr_pair.addr_m     = in_addr_m;

   fft_pair_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (in_done),
      .wr_data (wr_pair),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (occ)
   );

   // Credits: stored pairs plus butterflies still in the add stage.
   assign committed   = {1'b0, occ} + {1'b0, inflight};
   assign issue_ok    = (committed < (CNT_BITS + 1)'(DEPTH));
   assign issue_acc   = issue & issue_ok;
   assign done_credit = in_done & (inflight != '0);

   assign out_valid = ~fifo_empty;
   assign xfer      = out_valid & out_ready;
   assign empty     = fifo_empty & (inflight == '0);

   // In-flight counter and sticky protocol/overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight     <= '0;
         overflow_err <= 1'b0;
      end else begin
         inflight <= inflight + CNT_BITS'(issue_acc) - CNT_BITS'(done_credit);
         if (in_done & (fifo_full | (inflight == '0))) overflow_err <= 1'b1;
      end
   end

   // Phase register of the output serialiser.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) phase <= PH_SUM;
      else        phase <= phase_next;
   end

   // Phase next-state, FIFO pop and output word selection from the FIFO head.
   always_comb begin
      phase_next = phase;
      pop        = 1'b0;
      out_real   = head.a_p_b_real;
      out_imag   = head.a_p_b_imag;
      out_addr   = head.addr_p;
      case (phase)
         PH_SUM: begin
            if (xfer) phase_next = PH_DIFF;
         end
         PH_DIFF: begin
            out_real = head.a_m_b_real;
            out_imag = head.a_m_b_imag;
            out_addr = head.addr_m;
            if (xfer) begin
               phase_next = PH_SUM;
               pop        = 1'b1;
            end
         end
         default: phase_next = PH_SUM;
      endcase
   end

endmodule
